// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel PHY receiver: MSB-first bit stream on clk_32f,
// byte alignment on the idle/comma character, parallel byte out with valid strobe.
module serial_paralelo_rx #(
    parameter int unsigned BC_COUNT  = 4,
    parameter logic [7:0]  IDLE_CHAR = 8'hBC
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        ACTIVE
    } state_t;

    localparam logic [3:0] BC_LAST = 4'(BC_COUNT - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_nx;
    logic [3:0] bc_cnt;
    logic [3:0] bc_cnt_nx;
    logic [7:0] data_nx;
    logic       valid_nx;
    logic       is_idle;
    logic       boundary;

    assign is_idle  = (sr == IDLE_CHAR);
    assign boundary = (bit_cnt == 3'd0);

    // Alignment FSM: next state, counters and output byte selection
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt + 3'd1;
        bc_cnt_nx  = bc_cnt;
        data_nx    = data_out;
        valid_nx   = 1'b0;
        unique case (state)
            SEARCH: begin
                bit_cnt_nx = 3'd0;
                bc_cnt_nx  = 4'd0;
                if (is_idle) begin
                    bit_cnt_nx = 3'd1;
                    bc_cnt_nx  = 4'd1;
                    if (BC_COUNT == 1) begin
                        state_nx = ACTIVE;
                    end else begin
                        state_nx = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_idle && bc_cnt == BC_LAST) begin
                        state_nx = ACTIVE;
                    end else if (is_idle) begin
                        bc_cnt_nx = bc_cnt + 4'd1;
                    end else begin
                        state_nx   = SEARCH;
                        bc_cnt_nx  = 4'd0;
                        bit_cnt_nx = 3'd0;
                    end
                end
            end
            ACTIVE: begin
                if (boundary && !is_idle) begin
                    data_nx  = sr;
                    valid_nx = 1'b1;
                end
            end
            default: begin
                state_nx   = SEARCH;
                bit_cnt_nx = 3'd0;
                bc_cnt_nx  = 4'd0;
            end
        endcase
    end

    // Shift register, FSM state and registered outputs
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            sr        <= 8'h00;
            bit_cnt   <= 3'd0;
            bc_cnt    <= 4'd0;
            state     <= SEARCH;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            sr        <= {sr[6:0], data_in};
            bit_cnt   <= bit_cnt_nx;
            bc_cnt    <= bc_cnt_nx;
            state     <= state_nx;
            data_out  <= data_nx;
            valid_out <= valid_nx;
            active    <= (state_nx == ACTIVE);
        end
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Testbench for serial_paralelo_rx: directed and random serial streams
// compared cycle by cycle against a bit-position reference model.
module tb_serial_paralelo_rx;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out_4;
    logic       valid_out_4;
    logic       active_4;
    logic [7:0] data_out_1;
    logic       valid_out_1;
    logic       active_1;

    int errors = 0;
    int checks = 0;

    logic       bits[$];
    logic [7:0] e_data[2][4096];
    logic       e_val[2][4096];
    logic       e_act[2][4096];

    always #5 clk_32f = ~clk_32f;

    serial_paralelo_rx #(.BC_COUNT(4)) dut4 (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out_4),
        .valid_out(valid_out_4),
        .active   (active_4)
    );

    serial_paralelo_rx #(.BC_COUNT(1)) dut1 (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out_1),
        .valid_out(valid_out_1),
        .active   (active_1)
    );

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
    endtask

    task automatic push_rand_bits(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom_range(0, 1));
            bits.push_back(b);
        end
    endtask

    // Byte formed by stream bits j-7..j (bit j is the LSB), zeros before start
    function automatic logic [7:0] win(input int j);
        logic [7:0] w;
        int         idx;
        w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            idx = j - 7 + i;
            w = {w[6:0], (idx >= 0) ? bits[idx] : 1'b0};
        end
        return w;
    endfunction

    // Reference: find an idle at any bit position, then look at every 8th
    // bit position after it; expectation index t is the state after edge t.
    task automatic model(input int m, input int bcc);
        int         mode;
        int         anchor;
        int         cnt;
        logic [7:0] dout;
        logic [7:0] w;
        logic       v;
        mode   = 0;
        anchor = 0;
        cnt    = 0;
        dout   = 8'h00;
        for (int t = 0; t < bits.size(); t++) begin
            v = 1'b0;
            if (t >= 1) begin
                w = win(t - 1);
                if (mode == 0) begin
                    if (w == 8'hBC) begin
                        anchor = t;
                        cnt    = 1;
                        mode   = (bcc == 1) ? 2 : 1;
                    end
                end else if ((t - anchor) % 8 == 0) begin
                    if (mode == 1) begin
                        if (w == 8'hBC) begin
                            cnt++;
                            if (cnt == bcc) mode = 2;
                        end else begin
                            mode = 0;
                        end
                    end else if (w != 8'hBC) begin
                        dout = w;
                        v    = 1'b1;
                    end
                end
            end
            e_data[m][t] = dout;
            e_val[m][t]  = v;
            e_act[m][t]  = (mode == 2);
        end
    endtask

    task automatic run_stream(input string name);
        model(0, 4);
        model(1, 1);
        for (int t = 0; t < bits.size(); t++) begin
            data_in = bits[t];
            @(posedge clk_32f);
            #1;
            check($sformatf("%s valid4 t=%0d", name, t),
                  {7'd0, valid_out_4}, {7'd0, e_val[0][t]});
            check($sformatf("%s data4 t=%0d", name, t),
                  data_out_4, e_data[0][t]);
            check($sformatf("%s active4 t=%0d", name, t),
                  {7'd0, active_4}, {7'd0, e_act[0][t]});
            check($sformatf("%s valid1 t=%0d", name, t),
                  {7'd0, valid_out_1}, {7'd0, e_val[1][t]});
            check($sformatf("%s data1 t=%0d", name, t),
                  data_out_1, e_data[1][t]);
            check($sformatf("%s active1 t=%0d", name, t),
                  {7'd0, active_1}, {7'd0, e_act[1][t]});
        end
        bits.delete();
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        #1;
        check({name, " rst data4"}, data_out_4, 8'h00);
        check({name, " rst valid4"}, {7'd0, valid_out_4}, 8'h00);
        check({name, " rst active4"}, {7'd0, active_4}, 8'h00);
        check({name, " rst data1"}, data_out_1, 8'h00);
        check({name, " rst valid1"}, {7'd0, valid_out_1}, 8'h00);
        check({name, " rst active1"}, {7'd0, active_1}, 8'h00);
        repeat (2) @(posedge clk_32f);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int         nbc;
        logic [7:0] b;
        #2;
        do_reset("init");

        repeat (5) push_byte(8'hBC);
        push_byte(8'hA5);
        push_byte(8'h3C);
        push_byte(8'hBC);
        push_byte(8'hFF);
        run_stream("lock_data");

        do_reset("offset");
        push_rand_bits(3);
        repeat (4) push_byte(8'hBC);
        push_byte(8'h12);
        run_stream("offset");

        do_reset("break");
        repeat (2) push_byte(8'hBC);
        push_byte(8'h55);
        repeat (4) push_byte(8'hBC);
        push_byte(8'h77);
        run_stream("break");

        do_reset("midrst");
        repeat (4) push_byte(8'hBC);
        push_byte(8'h5A);
        bits.push_back(1'b1);
        bits.push_back(1'b1);
        bits.push_back(1'b0);
        bits.push_back(1'b0);
        run_stream("pre_rst");
        check("pre_rst active4", {7'd0, active_4}, 8'h01);
        do_reset("midrst");
        push_byte(8'hC3);
        repeat (4) push_byte(8'hBC);
        push_byte(8'h6E);
        run_stream("post_rst");

        do_reset("bc1");
        push_byte(8'hBC);
        push_byte(8'h81);
        run_stream("bc1");

        for (int it = 0; it < 8; it++) begin
            do_reset("rand");
            push_rand_bits($urandom_range(0, 7));
            nbc = $urandom_range(0, 6);
            repeat (nbc) push_byte(8'hBC);
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 3) == 0) b = 8'hBC;
                else b = 8'($urandom);
                push_byte(b);
            end
            run_stream($sformatf("rand%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
